brush_tracker: RTL

//  Per-frame brush position conditioner, directly upstream of frame_buffer.
//  - Takes raw pointer detections (centroid x/y plus found flag) from the camera/detection path.
//  - Qualifies them: acquire/lost hysteresis, jump rejection, moving average.
//  - Drives x_in/y_in/color_in/sw_in of frame_buffer; values are held constant for a whole frame.
//  - When the pen is up, it parks the position off-canvas so frame_buffer never writes.

---
 rtl/brush_pkg.sv | 26 ++
 rtl/pos_avg_axis.sv | 49 ++++
 rtl/brush_tracker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/brush_pkg.sv
// Shared types and constants for the brush position conditioner and its
// downstream frame_buffer (palette codes, off-canvas park position).
package brush_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_COAST   = 2'd3
    } brush_state_e;

    localparam logic [9:0] PARK_X = 10'h3FF;
    localparam logic [8:0] PARK_Y = 9'h1FF;

    localparam logic [3:0] COL_BLACK  = 4'd0;
    localparam logic [3:0] COL_WHITE  = 4'd1;
    localparam logic [3:0] COL_RED    = 4'd2;
    localparam logic [3:0] COL_GREEN  = 4'd3;
    localparam logic [3:0] COL_BLUE   = 4'd4;
    localparam logic [3:0] COL_YELLOW = 4'd5;
    localparam logic [3:0] COL_CYAN   = 4'd6;
    localparam logic [3:0] COL_PURPLE = 4'd7;

    localparam logic [2:0] SW_RESET = 3'd0;

endpackage

// File: rtl/pos_avg_axis.sv
// One coordinate axis: moving-average history with running sum, preload on
// track start, and an |sample - ref| <= JUMP_MAX qualifier.
module pos_avg_axis #(
    parameter int W        = 10,
    parameter int AVG_LOG2 = 2,
    parameter int JUMP_MAX = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] sample_i,
    input  logic [W-1:0] ref_i,
    input  logic         preload_i,
    input  logic         update_i,
    output logic [W-1:0] avg_o,
    output logic         near_o
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = W + AVG_LOG2;
    localparam logic [W:0] JMAX = (W+1)'(JUMP_MAX);

    // One extra bit keeps the difference exact for any pair of coordinates.
    function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic [W-1:0]  hist_q [DEPTH];
    logic [SW-1:0] sum_q;

    assign avg_o  = sum_q[SW-1:AVG_LOG2];
    assign near_o = (abs_diff(sample_i, ref_i) <= JMAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            sum_q <= '0;
        end else if (preload_i) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= sample_i;
            sum_q <= SW'(sample_i) << AVG_LOG2;
        end else if (update_i) begin
            for (int i = DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= sample_i;
            sum_q     <= sum_q + SW'(sample_i) - SW'(hist_q[DEPTH-1]);
        end
    end

endmodule

// File: rtl/brush_tracker.sv
// Per-frame brush position conditioner feeding frame_buffer: capture, acquire/
// lost hysteresis, jump rejection and moving average; parks off-canvas when up.
module brush_tracker
    import brush_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 360,
    parameter int AVG_LOG2    = 2,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 4,
    parameter int JUMP_MAX    = 64
) (
    input  logic       pixel_clk_in,
    input  logic       rst_n_in,
    input  logic       nf_in,
    input  logic       det_valid_in,
    input  logic       det_found_in,
    input  logic [9:0] det_x_in,
    input  logic [8:0] det_y_in,
    input  logic [3:0] color_in,
    input  logic [2:0] sw_in,
    output logic [9:0] x_out,
    output logic [8:0] y_out,
    output logic [3:0] color_out,
    output logic [2:0] sw_out,
    output logic       pen_down_out
);

    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM  = 9'(V_ACTIVE);
    localparam logic [7:0] ACQ_N  = 8'(ACQ_FRAMES);
    localparam logic [7:0] LOST_N = 8'(LOST_FRAMES);

    logic         pend_found_q;
    logic [9:0]   pend_x_q;
    logic [8:0]   pend_y_q;
    logic         det_ok;

    brush_state_e state_q, state_d;
    logic [7:0]   acq_q, acq_d;
    logic [7:0]   miss_q, miss_d;
    logic [9:0]   prev_x_q, prev_x_d;
    logic [8:0]   prev_y_q, prev_y_d;
    logic         preload, update;

    logic [9:0]   avg_x, ref_x;
    logic [8:0]   avg_y, ref_y;
    logic         near_x, near_y, good;

    logic         commit_p1_q;
    logic [3:0]   col_p1_q;
    logic [2:0]   sw_p1_q;

    logic [9:0]   x_q;
    logic [8:0]   y_q;
    logic [3:0]   col_q;
    logic [2:0]   sw_q;
    logic         pen_q;

    assign det_ok = det_found_in && (det_x_in < H_LIM) && (det_y_in < V_LIM);

    // A detection arriving with nf_in belongs to the next frame, so it wins over the clear.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_found_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
        end else if (det_valid_in) begin
            pend_found_q <= det_ok;
            pend_x_q     <= det_x_in;
            pend_y_q     <= det_y_in;
        end else if (nf_in) begin
            pend_found_q <= 1'b0;
        end
    end

    assign ref_x = (state_q == ST_ACQUIRE) ? prev_x_q : avg_x;
    assign ref_y = (state_q == ST_ACQUIRE) ? prev_y_q : avg_y;
    assign good  = pend_found_q && ((state_q == ST_IDLE) || (near_x && near_y));

    pos_avg_axis #(.W(10), .AVG_LOG2(AVG_LOG2), .JUMP_MAX(JUMP_MAX)) u_axis_x (
        .clk_i     (pixel_clk_in),
        .rst_n_i   (rst_n_in),
        .sample_i  (pend_x_q),
        .ref_i     (ref_x),
        .preload_i (preload),
        .update_i  (update),
        .avg_o     (avg_x),
        .near_o    (near_x)
    );

    pos_avg_axis #(.W(9), .AVG_LOG2(AVG_LOG2), .JUMP_MAX(JUMP_MAX)) u_axis_y (
        .clk_i     (pixel_clk_in),
        .rst_n_i   (rst_n_in),
        .sample_i  (pend_y_q),
        .ref_i     (ref_y),
        .preload_i (preload),
        .update_i  (update),
        .avg_o     (avg_y),
        .near_o    (near_y)
    );

    always_comb begin
        state_d  = state_q;
        acq_d    = acq_q;
        miss_d   = miss_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        preload  = 1'b0;
        update   = 1'b0;
        if (nf_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (good) begin
                        prev_x_d = pend_x_q;
                        prev_y_d = pend_y_q;
                        if (ACQ_N == 8'd1) begin
                            state_d = ST_TRACK;
                            preload = 1'b1;
                            acq_d   = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            acq_d   = 8'd1;
                        end
                    end
                end
                ST_ACQUIRE: begin
                    prev_x_d = pend_x_q;
                    prev_y_d = pend_y_q;
                    if (good) begin
                        if (acq_q + 8'd1 == ACQ_N) begin
                            state_d = ST_TRACK;
                            preload = 1'b1;
                            acq_d   = '0;
                        end else begin
                            acq_d = acq_q + 8'd1;
                        end
                    end else if (pend_found_q) begin
                        acq_d = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        acq_d   = '0;
                    end
                end
                ST_TRACK: begin
                    if (good) begin
                        update = 1'b1;
                    end else if (LOST_N == 8'd1) begin
                        state_d = ST_IDLE;
                        miss_d  = '0;
                    end else begin
                        state_d = ST_COAST;
                        miss_d  = 8'd1;
                    end
                end
                ST_COAST: begin
                    if (good) begin
                        state_d = ST_TRACK;
                        miss_d  = '0;
                        update  = 1'b1;
                    end else if (miss_q + 8'd1 == LOST_N) begin
                        state_d = ST_IDLE;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage 1: commit the frame's sample into FSM, counters and history.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            acq_q       <= '0;
            miss_q      <= '0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            commit_p1_q <= 1'b0;
            col_p1_q    <= COL_BLACK;
            sw_p1_q     <= SW_RESET;
        end else begin
            state_q     <= state_d;
            acq_q       <= acq_d;
            miss_q      <= miss_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            commit_p1_q <= nf_in;
            if (nf_in) begin
                col_p1_q <= color_in;
                sw_p1_q  <= sw_in;
            end
        end
    end

    // Stage 2: all outputs move together and then hold for the rest of the frame.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q   <= PARK_X;
            y_q   <= PARK_Y;
            col_q <= COL_BLACK;
            sw_q  <= SW_RESET;
            pen_q <= 1'b0;
        end else if (commit_p1_q) begin
            if ((state_q == ST_TRACK) || (state_q == ST_COAST)) begin
                pen_q <= 1'b1;
                x_q   <= avg_x;
                y_q   <= avg_y;
            end else begin
                pen_q <= 1'b0;
                x_q   <= PARK_X;
                y_q   <= PARK_Y;
            end
            col_q <= col_p1_q;
            sw_q  <= sw_p1_q;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign color_out    = col_q;
    assign sw_out       = sw_q;
    assign pen_down_out = pen_q;

endmodule
